// File: rtl/a0_trace_pkg.sv
// Shared constants and types for the a0 change tracer.
package a0_trace_pkg;
   localparam int A0_WIDTH = 32;
   localparam int A0_DEPTH = 16;
   localparam int A0_CNT_W = $clog2(A0_DEPTH) + 1;
   typedef logic [A0_CNT_W-1:0] a0_cnt_t;
endpackage

// File: rtl/a0_trace_if.sv
// Valid/ready stream carrying traced a0 values to the consumer.
interface a0_trace_if #(
   parameter int WIDTH = 32
) ();
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/a0_trace_fifo.sv
// Synchronous FIFO; a full FIFO still accepts a push when popped the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wr, rd;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[head_q];

   assign wr = push_i && (!full_o || pop_i);
   assign rd = pop_i && !empty_o;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (wr) tail_d = tail_q + AW'(1);
      if (rd) head_d = head_q + AW'(1);
      unique case ({wr, rd})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr) mem_q[tail_q] <= wdata_i;
   end
endmodule

// File: rtl/a0_trace.sv
// Records every change of the processor's a0 register into a drainable FIFO.
module a0_trace
   import a0_trace_pkg::*;
#(
   parameter int WIDTH = A0_WIDTH,
   parameter int DEPTH = A0_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       a0_in,
   input  logic                   en,
   input  logic                   clr_ovf,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   a0_trace_if.master             trc
);
   logic [WIDTH-1:0] prev_q;
   logic             ovf_q, ovf_d;
   logic             push, pop, full, empty;

   assign push = en && (a0_in != prev_q);
   assign pop  = trc.out_valid && trc.out_ready;

   always_comb begin
      ovf_d = ovf_q;
      if (push && full && !pop) ovf_d = 1'b1;
      else if (clr_ovf)         ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prev_q <= a0_in;
         ovf_q  <= ovf_d;
      end
   end

   assign overflow      = ovf_q;
   assign trc.out_valid = !empty;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (a0_in),
      .pop_i   (pop),
      .rdata_o (trc.out_data),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );
endmodule

// File: doc/a0_trace.md
A0_TRACE -- requirements
Module: a0_trace

Interface
REQ-001 Parameter WIDTH, default 32, data width of the traced register value.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 a0_in  input  WIDTH  live a0 value from the processor top.
REQ-006 en  input  1  capture enable; when low, changes are not recorded.
REQ-007 out_data  output  WIDTH  value at the FIFO head.
REQ-008 out_valid  output  1  high when the FIFO holds at least one entry.
REQ-009 out_ready  input  1  consumer accepts the head entry when high together with out_valid.
REQ-010 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag; a change was dropped because the FIFO was full.
REQ-012 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-013 A prev register shall sample a0_in on every clock edge, regardless of en.
REQ-014 push shall be true in a cycle when en=1 and a0_in != prev.
REQ-015 On push with space available, a0_in shall be written to the tail at that edge; out_valid shall be high in the next cycle if the FIFO was empty (1-cycle latency).
REQ-016 pop shall occur at an edge where out_valid=1 and out_ready=1; the head shall advance and out_data shall show the next entry in the following cycle.
REQ-017 out_data shall be driven from storage at the head pointer; its value while out_valid=0 is don't-care.
REQ-018 Pointers shall be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 count shall track occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-020 When full and a pop occurs, a push in the same cycle shall be accepted, the entry shall not be dropped, and count shall stay DEPTH.
REQ-021 When full with no pop, a push shall be dropped, storage shall be unchanged, and overflow shall be set at that edge.
REQ-022 When empty, simultaneous push and pop cannot occur; a push shall be written and out_valid shall rise the next cycle.
REQ-023 overflow shall clear on clr_ovf=1; if a drop happens in the same cycle, set shall win.
REQ-024 When en falls, entries already queued shall remain and stay drainable.
REQ-025 No combinational path shall exist from a0_in or en to any output; out_valid and count depend only on registered state.

Reset
REQ-026 While rst=0, all of the following shall hold asynchronously: prev=0, head=0, tail=0, count=0, out_valid=0, overflow=0.
REQ-027 Storage contents shall not be reset.
REQ-028 Reset asserted mid-operation shall discard all queued entries.
REQ-029 After rst deasserts, a non-zero a0_in with en=1 shall be captured on the first edge, because prev resets to 0.

Structure
REQ-030 A shared package a0_trace_pkg shall hold the default WIDTH and DEPTH constants and a typedef for the occupancy count.
REQ-031 Buffering shall be a sub-module sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count ports.
REQ-032 a0_trace shall contain only the change detector, overflow flag and sync_fifo instance.
REQ-033 The block shall sit downstream of the processor top, consuming its a0 output; the processor shall be unmodified.

Verification
REQ-034 Reset release, en=1, a0_in steps 0->5->5->7 on consecutive cycles, out_ready=0 -> count=2, head=5; after one pop, head=7.
REQ-035 en=0 while a0_in toggles 1,2,3 -> count stays 0 and out_valid stays 0.
REQ-036 16 distinct changes with out_ready=0, then a 17th change -> count=16, overflow=1, entries 1..16 drain in order.
REQ-037 FIFO full, a new change with out_ready=1 in the same cycle -> no drop, overflow stays 0, count=16, new value appears last.
REQ-038 Drop and clr_ovf=1 in the same cycle -> overflow=1; clr_ovf=1 alone on the next cycle -> overflow=0.
REQ-039 rst pulsed low asynchronously (between clock edges) with count=9 -> out_valid=0 and count=0 immediately; tail write pointer at 0 after release.
